ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction prefetch stage sitting directly upstream of the IF/ID pipeline register. It generates sequential fetch addresses, and talks to a variable-latency instruction memory through a one-outstanding req/ack handshake. Fetched {pc, instruction} pairs are buffered in a small FIFO and presented to decode with a valid/ready handshake. A redirect from ID (branch/jump/jr target) flushes the queue and restarts fetch, and safely drains any in-flight memory request.

## Interface

Parameters:
- PTR_W, default 2: queue pointer width; DEPTH = 1<<PTR_W entries.
- RESET_PC, default 32'h0000_3000: first fetch address after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0 internally.
- mem_req  out  1  instruction memory request.
- mem_addr  out  32  request address; stable while mem_req=1 and no ack.
- mem_ack  in  1  request completed this cycle; mem_rdata valid.
- mem_rdata  in  32  fetched instruction word.
- out_valid  out  1  head entry valid.
- out_pc  out  32  PC of head instruction.
- out_ins  out  32  head instruction.
- out_ready  in  1  decode accepts head (pop when out_valid & out_ready).
- count  out  PTR_W+1  number of queued entries.

## Operation

- Queue: DEPTH-entry circular FIFO of {pc, ins}.
  - Push on accepted ack; pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - out_valid = (count != 0); out_pc and out_ins show the head entry.
- Request FSM, mem_req = (state == REQ || state == DISCARD):
  - IDLE: no request. Go to REQ when count_next < DEPTH.
  - REQ: mem_addr = fetch_pc.
    - On mem_ack without redirect: push {fetch_pc, mem_rdata}, fetch_pc += 4, mem_addr follows. Stay in REQ if count_next < DEPTH, else go to IDLE.
  - DISCARD: mem_req held at the stale mem_addr until ack. ack data is dropped; then go to REQ at fetch_pc.
- Redirect (priority over everything else): fetch_pc ← {redirect_pc[31:2], 2'b00}; all entries flushed; any same-cycle push is dropped.
  - In IDLE: go to REQ.
  - In REQ or DISCARD without ack: go to DISCARD. The request is never withdrawn mid-handshake.
  - In REQ or DISCARD with ack: drop the data and go to REQ at the new address.
  - A same-cycle pop completes normally; decode owns that decision.
- A push to a full queue cannot occur: a request is only issued when a free slot exists.
- fetch_pc wraps modulo 2^32.
- Reset values: state IDLE, fetch_pc = mem_addr = RESET_PC, count = 0, pointers = 0, mem_req = 0, out_valid = 0, out_pc = 0, out_ins = 0 (entry storage cleared).
- Reset asserted mid-request abandons the handshake. The memory side must tolerate a dropped req.

## Timing

- The first request is asserted on the first clock edge after reset deasserts.
- ack → out_valid latency: 1 cycle (0 with bypass, see Configuration).
- With a zero-wait memory (ack in the same cycle as req) and out_ready = 1: sustained throughput of 1 instruction per cycle.
- Redirect → new address on mem_addr:
  - 1 cycle if no request is pending or the ack coincides with the redirect;
  - otherwise 1 cycle after the stale ack.
- Redirect → out_valid = 0 on the next cycle.

## Configuration

- IFQ_BYPASS_EN defined: when the queue is empty, a REQ-state ack without redirect drives out_valid = 1, out_pc = fetch_pc, out_ins = mem_rdata combinationally in the same cycle.
  - If out_ready = 1, the entry is not written and count stays 0.
  - Otherwise the entry is pushed as normal.
- IFQ_BYPASS_EN undefined: outputs are purely registered; minimum ack → out_valid latency is 1 cycle.

## Test plan

- Reset held 2 cycles → mem_req = 0, out_valid = 0, count = 0, mem_addr = 0x3000. First edge after release → mem_req = 1, mem_addr = 0x3000.
- Zero-wait memory, out_ready = 1, mem[0x3000..] = 0x20080001, 0x20090002, 0x01095020 → out stream (0x3000, 0x20080001), (0x3004, 0x20090002), (0x3008, 0x01095020) on consecutive cycles; count ≤ 1.
- out_ready = 0, zero-wait memory → count reaches 4, mem_req drops with mem_addr = 0x3010. One cycle of out_ready = 1 pops pc 0x3000; mem_req re-asserts at 0x3010 the next cycle; count returns to 4.
- ack delayed 3 cycles, redirect to 0x3401 while request to 0x3008 pending → next cycle count = 0, out_valid = 0, mem_addr stays 0x3008. Its ack data is dropped; mem_addr becomes 0x3400; the first delivered pc is 0x3400.
- redirect to 0x3100 in the same cycle as ack for 0x3004 → word dropped, next cycle mem_req = 1, mem_addr = 0x3100; no entry with pc 0x3004 is ever delivered.
- IFQ_BYPASS_EN build, empty queue, ack with rdata = 0x8C0A0000 and out_ready = 1 → out_valid = 1 in the ack cycle with out_ins = 0x8C0A0000; count stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction prefetch stage. Generates sequential fetch
//               addresses, issues one-outstanding req/ack transactions to a
//               variable-latency instruction memory, buffers {pc, ins} pairs
//               in a small circular FIFO and presents them to decode with a
//               valid/ready handshake. A redirect flushes the queue and
//               restarts fetch; an in-flight request is drained, never
//               withdrawn.
//               Optional feature macro: IFQ_BYPASS_EN (empty-queue
//               combinational bypass from memory to the decode outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int          PTR_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_ins,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam int             DEPTH_N    = 1 << PTR_W;
    localparam logic [PTR_W:0] FULL_COUNT = {1'b1, {PTR_W{1'b0}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      stale_addr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_next;
    logic [31:0]      pc_mem  [DEPTH_N];
    logic [31:0]      ins_mem [DEPTH_N];
    logic             ack_in_req;
    logic             accept;
    logic             queue_pop;
    logic             push;
    logic             bypass_take;
    logic             head_valid;
    logic [31:0]      head_pc;
    logic [31:0]      head_ins;
    logic             unused_redirect_lsbs;

    // The low address bits of a redirect target are forced to zero.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign head_valid = (count != '0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_ins   = ins_mem[rd_ptr];

    // Only an ack for a live (non-stale) request carries a usable word.
    assign ack_in_req = (state == S_REQ) && mem_ack;
    assign accept     = ack_in_req && !redirect;
    assign queue_pop  = head_valid && out_ready;

`ifdef IFQ_BYPASS_EN
    logic bypass_hit;

    // Empty queue: forward the arriving word straight to decode.
    assign bypass_hit  = accept && !head_valid;
    assign bypass_take = bypass_hit && out_ready;
    assign out_valid   = head_valid || bypass_hit;
    assign out_pc      = bypass_hit ? fetch_pc  : head_pc;
    assign out_ins     = bypass_hit ? mem_rdata : head_ins;
`else
    assign bypass_take = 1'b0;
    assign out_valid   = head_valid;
    assign out_pc      = head_pc;
    assign out_ins     = head_ins;
`endif

    // A word consumed by the bypass never occupies a slot.
    assign push       = accept && !bypass_take;
    assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, queue_pop};

    // Request FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request FSM next-state logic; redirect overrides every other cause.
    always_comb begin
        state_next = state;
        if (redirect) begin
            if (state == S_IDLE) begin
                state_next = S_REQ;
            end else begin
                // An outstanding request must be drained before reuse.
                state_next = mem_ack ? S_REQ : S_DISCARD;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (count_next < FULL_COUNT) begin
                        state_next = S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state_next = (count_next < FULL_COUNT) ? S_REQ : S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Request FSM outputs; a draining request keeps its original address.
    always_comb begin
        mem_req  = (state == S_REQ) || (state == S_DISCARD);
        mem_addr = (state == S_DISCARD) ? stale_addr : fetch_pc;
    end

    // Fetch address and the address of a request being drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            if ((state == S_REQ) && !mem_ack) begin
                stale_addr <= fetch_pc;
            end
        end else if (ack_in_req) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (queue_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Entry storage, cleared on reset so the idle outputs read zero.
    for (genvar i = 0; i < DEPTH_N; i++) begin : g_entry
        // Write a slot when it is the push target.
        always_ff @(posedge clock) begin
            if (reset) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end else if (push && (wr_ptr == PTR_W'(i))) begin
                pc_mem[i]  <= fetch_pc;
                ins_mem[i] <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. A queue-based model
//               tracks outstanding/stale requests and buffered words; a
//               negedge process compares every cycle, and directed
//               scenarios pin the model with hand-computed values.
//               Honours IFQ_BYPASS_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    localparam int          PTR_W    = 2;
    localparam int          DEPTH    = 1 << PTR_W;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef IFQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           redirect = 1'b0;
    logic [31:0]    redirect_pc = '0;
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic           mem_ack;
    logic [31:0]    mem_rdata;
    logic           out_valid;
    logic [31:0]    out_pc;
    logic [31:0]    out_ins;
    logic           out_ready = 1'b0;
    logic [PTR_W:0] count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ifetch_queue #(.PTR_W(PTR_W), .RESET_PC(RESET_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_ins    (out_ins),
        .out_ready  (out_ready),
        .count      (count)
    );

    always #5 clock = ~clock;

    // Instruction memory contents.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_3000: memf = 32'h2008_0001;
            32'h0000_3004: memf = 32'h2009_0002;
            32'h0000_3008: memf = 32'h0109_5020;
            32'h0000_3500: memf = 32'h8C0A_0000;
            default:       memf = a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Memory responder: acks after 'latency' extra cycles of request.
    int latency  = 0;
    int wait_cnt = 0;
    assign mem_ack   = mem_req && (wait_cnt >= latency);
    assign mem_rdata = memf(mem_addr);
    always @(posedge clock) begin
        if (reset || !mem_req || mem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mq[$];
    logic [31:0] m_fetch_pc  = RESET_PC;
    logic [31:0] m_drop_addr = RESET_PC;
    bit          m_busy = 0;
    bit          m_drop = 0;
    bit          model_live = 0;
    bit          m_acked, m_empty;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            mq.delete();
            m_fetch_pc  = RESET_PC;
            m_drop_addr = RESET_PC;
            m_busy      = 0;
            m_drop      = 0;
            model_live  = 1;
        end else if (model_live) begin
            m_acked = m_busy && mem_ack;
            m_empty = (mq.size() == 0);
            if (!m_empty && out_ready) void'(mq.pop_front());
            if (redirect) begin
                mq.delete();
                if (m_busy && !mem_ack) begin
                    if (!m_drop) m_drop_addr = m_fetch_pc;
                    m_drop = 1;
                end else begin
                    m_drop = 0;
                end
                m_busy     = 1;
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (m_acked && m_drop) begin
                m_drop = 0;
            end else if (m_acked) begin
                if (!(BYPASS && m_empty && out_ready))
                    mq.push_back({m_fetch_pc, memf(m_fetch_pc)});
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_busy     = (mq.size() < DEPTH);
            end else if (!m_busy) begin
                m_busy = (mq.size() < DEPTH);
            end
        end
    end

    // Delivered-entry log and occupancy tracking for directed checks.
    logic [31:0] log_pc[$];
    logic [31:0] log_ins[$];
    int          log_cyc[$];
    int          max_cnt = 0;

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clock) begin
        if (model_live) begin
            bit          byp;
            bit          exp_valid;
            logic [31:0] exp_pc, exp_ins;
            byp = BYPASS && m_busy && !m_drop && mem_ack && !redirect && (mq.size() == 0);
            exp_valid = (mq.size() != 0) || byp;
            exp_pc  = byp ? m_fetch_pc : mq[0][63:32];
            exp_ins = byp ? memf(m_fetch_pc) : mq[0][31:0];
            chk("mem_req",   mem_req,   m_busy);
            chk("mem_addr",  mem_addr,  m_drop ? m_drop_addr : m_fetch_pc);
            chk("out_valid", out_valid, exp_valid);
            chk("count",     count,     mq.size());
            if (exp_valid) begin
                chk("out_pc",  out_pc,  exp_pc);
                chk("out_ins", out_ins, exp_ins);
            end
            if (out_valid === 1'b1 && out_ready) begin
                log_pc.push_back(out_pc);
                log_ins.push_back(out_ins);
                log_cyc.push_back(cyc);
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        step();
        step();
        chk("rst_mem_req",   mem_req,   1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count",     count,     0);
        chk("rst_mem_addr",  mem_addr,  32'h3000);
        chk("rst_out_pc",    out_pc,    32'h0);
        chk("rst_out_ins",   out_ins,   32'h0);
        reset = 1'b0;
        log_pc.delete();
        log_ins.delete();
        log_cyc.delete();
        max_cnt = 0;
    endtask

    initial begin
        int  base;
        bit  found;

        // Zero-wait stream with decode always ready.
        latency   = 0;
        out_ready = 1'b1;
        do_reset();
        step();
        chk("first_req",  mem_req,  1'b1);
        chk("first_addr", mem_addr, 32'h3000);
        repeat (6) step();
        if (log_pc.size() < 3) begin
            fail_bound("stream_len");
        end else begin
            chk("stream_pc0",  log_pc[0],  32'h3000);
            chk("stream_ins0", log_ins[0], 32'h2008_0001);
            chk("stream_pc1",  log_pc[1],  32'h3004);
            chk("stream_ins1", log_ins[1], 32'h2009_0002);
            chk("stream_pc2",  log_pc[2],  32'h3008);
            chk("stream_ins2", log_ins[2], 32'h0109_5020);
            chk("stream_gap1", log_cyc[1] - log_cyc[0], 1);
            chk("stream_gap2", log_cyc[2] - log_cyc[1], 1);
        end
        chk("stream_count_le1", max_cnt <= 1, 1'b1);

        // Fill to capacity, then a single pop re-opens fetch.
        out_ready = 1'b0;
        do_reset();
        repeat (8) step();
        chk("full_count",    count,     4);
        chk("full_mem_req",  mem_req,   1'b0);
        chk("full_mem_addr", mem_addr,  32'h3010);
        chk("full_head_pc",  out_pc,    32'h3000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_mem_req",  mem_req,  1'b1);
        chk("pop_mem_addr", mem_addr, 32'h3010);
        chk("pop_count",    count,    3);
        step();
        step();
        chk("refill_count",   count,   4);
        chk("refill_mem_req", mem_req, 1'b0);
        chk("pop_log_len", log_pc.size(), 1);
        if (log_pc.size() >= 1) chk("pop_log_pc", log_pc[0], 32'h3000);

        // Redirect while a slow request is pending: drain, then restart.
        latency   = 3;
        out_ready = 1'b0;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (mem_req === 1'b1 && mem_addr === 32'h3008 && mem_ack === 1'b0) found = 1;
        end
        if (!found) fail_bound("wait_req_3008");
        redirect    = 1'b1;
        redirect_pc = 32'h3401;
        base        = log_pc.size();
        step();
        redirect = 1'b0;
        chk("rd_count",     count,     0);
        chk("rd_out_valid", out_valid, 1'b0);
        chk("rd_mem_addr",  mem_addr,  32'h3008);
        chk("rd_mem_req",   mem_req,   1'b1);
        found = (mem_ack === 1'b1);
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (mem_ack === 1'b1) found = 1;
        end
        if (!found) fail_bound("wait_stale_ack");
        chk("stale_ack_addr", mem_addr, 32'h3008);
        step();
        chk("restart_addr", mem_addr, 32'h3400);
        chk("restart_req",  mem_req,  1'b1);
        out_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (log_pc.size() > base) found = 1;
        end
        if (!found) begin
            fail_bound("wait_first_delivery");
        end else begin
            chk("rd_first_pc",  log_pc[base],  32'h3400);
            chk("rd_first_ins", log_ins[base], 32'hC0DE_3400);
        end

        // Redirect coinciding with an ack: the word is dropped.
        latency   = 1;
        out_ready = 1'b1;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (mem_req === 1'b1 && mem_ack === 1'b1 && mem_addr === 32'h3004) found = 1;
        end
        if (!found) fail_bound("wait_ack_3004");
        redirect    = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect = 1'b0;
        chk("co_mem_req",  mem_req,  1'b1);
        chk("co_mem_addr", mem_addr, 32'h3100);
        repeat (10) step();
        found = 0;
        foreach (log_pc[k]) if (log_pc[k] == 32'h3004) found = 1;
        chk("co_no_3004", found, 1'b0);
        if (log_pc.size() < 2) begin
            fail_bound("co_log_len");
        end else begin
            chk("co_pc0", log_pc[0], 32'h3000);
            chk("co_pc1", log_pc[1], 32'h3100);
        end

`ifdef IFQ_BYPASS_EN
        // Bypass: ack into an empty queue reaches decode in the same cycle.
        latency   = 0;
        out_ready = 1'b1;
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h3500;
        step();
        redirect = 1'b0;
        chk("byp_valid", out_valid, 1'b1);
        chk("byp_pc",    out_pc,    32'h3500);
        chk("byp_ins",   out_ins,   32'h8C0A_0000);
        chk("byp_count", count,     0);
`endif

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
